// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and default width shared by the ALU and its mul/div engine.
package alu_pkg;
  localparam int DEF_WIDTH = 32;
  localparam logic [3:0] OP_SLL   = 4'b0000;
  localparam logic [3:0] OP_SRL   = 4'b0001;
  localparam logic [3:0] OP_SRA   = 4'b0010;
  localparam logic [3:0] OP_ROR   = 4'b0011;
  localparam logic [3:0] OP_SLT   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_ADD   = 4'b0110;
  localparam logic [3:0] OP_SUB   = 4'b0111;
  localparam logic [3:0] OP_AND   = 4'b1000;
  localparam logic [3:0] OP_OR    = 4'b1001;
  localparam logic [3:0] OP_NOR   = 4'b1010;
  localparam logic [3:0] OP_XOR   = 4'b1011;
  localparam logic [3:0] OP_MULT  = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1101;
  localparam logic [3:0] OP_DIV   = 4'b1110;
  localparam logic [3:0] OP_DIVU  = 4'b1111;
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: radix-2 shift-add multiplier / restoring divider on operand magnitudes,
// one step per cycle for WIDTH cycles; o_res applies the sign correction combinationally.
module muldiv_iter import alu_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_signed,
  input  logic               i_div,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_res
);
  localparam int SHW = $clog2(WIDTH);
  logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d, b_q, b_d, a_mag, b_mag;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, div_q, div_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic [WIDTH:0] madd, sh, dsub;
  logic [2*WIDTH-1:0] prod;
  always_comb begin
    a_mag  = (i_signed & i_a[WIDTH-1]) ? -i_a : i_a;
    b_mag  = (i_signed & i_b[WIDTH-1]) ? -i_b : i_b;
    madd   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    sh     = {acc_q, lo_q[WIDTH-1]};
    dsub   = sh - {1'b0, b_q};
    acc_d  = acc_q;
    lo_d   = lo_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    div_d  = div_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    if (i_start) begin
      acc_d  = '0;
      lo_d   = a_mag;
      b_d    = b_mag;
      cnt_d  = '1;
      busy_d = 1'b1;
      div_d  = i_div;
      qneg_d = i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      rneg_d = i_signed & i_a[WIDTH-1];
    end else if (busy_q) begin
      acc_d  = div_q ? (dsub[WIDTH] ? sh[WIDTH-1:0] : dsub[WIDTH-1:0]) : madd[WIDTH:1];
      lo_d   = div_q ? {lo_q[WIDTH-2:0], ~dsub[WIDTH]} : {madd[0], lo_q[WIDTH-1:1]};
      cnt_d  = cnt_q - SHW'(1);
      busy_d = cnt_q != '0;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q  <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      div_q  <= div_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
  assign prod   = {acc_q, lo_q};
  assign o_done = busy_q & (cnt_q == '0);
  assign o_res  = div_q ? {rneg_q ? -acc_q : acc_q, qneg_q ? -lo_q : lo_q}
                        : (qneg_q ? -prod : prod);
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: registered valid/ready ALU with iterative multiply/divide (HI/LO result).
// The mul/div engine is built only when ALU_MULDIV_EN is defined; otherwise 11xx ops return 0.
module alu_muldiv import alu_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_res,
  output logic [WIDTH-1:0] o_hi,
  output logic             o_zero,
  output logic             o_overflow,
  output logic             o_divzero
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] WL = (SHW+1)'(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d, sum, dif, alu_res, alu_hi;
  logic ovf_q, ovf_d, dz_q, dz_d, alu_ovf, alu_dz, multi, accept;
  logic [SHW-1:0] shamt;
  assign shamt  = i_A[SHW-1:0];
  assign sum    = i_A + i_B;
  assign dif    = i_A - i_B;
  assign accept = i_valid & (state_q == IDLE);
  always_comb begin
    alu_res = '0;
    alu_hi  = '0;
    alu_ovf = 1'b0;
    alu_dz  = 1'b0;
    multi   = 1'b0;
    case (i_op)
      OP_SLL:  alu_res = i_B << shamt;
      OP_SRL:  alu_res = i_B >> shamt;
      OP_SRA:  alu_res = $signed(i_B) >>> shamt;
      OP_ROR:  alu_res = (i_B >> shamt) | (i_B << (WL - {1'b0, shamt}));
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(i_A) < $signed(i_B)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, i_A < i_B};
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (i_A[WIDTH-1] == i_B[WIDTH-1]) & (sum[WIDTH-1] != i_A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif;
        alu_ovf = (i_A[WIDTH-1] != i_B[WIDTH-1]) & (dif[WIDTH-1] != i_A[WIDTH-1]);
      end
      OP_AND:  alu_res = i_A & i_B;
      OP_OR:   alu_res = i_A | i_B;
      OP_NOR:  alu_res = ~(i_A | i_B);
      OP_XOR:  alu_res = i_A ^ i_B;
`ifdef ALU_MULDIV_EN
      // Divide by zero never enters the engine; it completes in one cycle.
      OP_DIV, OP_DIVU: begin
        if (i_B == '0) begin
          alu_res = '1;
          alu_hi  = i_A;
          alu_dz  = 1'b1;
        end else begin
          multi = 1'b1;
        end
      end
      default: multi = 1'b1;
`else
      default: ;
`endif
    endcase
  end
`ifdef ALU_MULDIV_EN
  logic eng_done;
  logic [2*WIDTH-1:0] eng_res;
  muldiv_iter #(.WIDTH(WIDTH)) u_eng (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (accept & multi),
    .i_signed (~i_op[0]),
    .i_div    (i_op[1]),
    .i_a      (i_A),
    .i_b      (i_B),
    .o_done   (eng_done),
    .o_res    (eng_res)
  );
`endif
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    hi_d    = hi_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (accept & multi) begin
          state_d = i_op[1] ? DIV : MUL;
        end else if (accept) begin
          state_d = DONE;
          res_d   = alu_res;
          hi_d    = alu_hi;
          ovf_d   = alu_ovf;
          dz_d    = alu_dz;
        end
      end
`ifdef ALU_MULDIV_EN
      MUL, DIV: state_d = eng_done ? FIX : state_q;
      FIX: begin
        state_d       = DONE;
        {hi_d, res_d} = eng_res;
        ovf_d         = 1'b0;
        dz_d          = 1'b0;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      hi_q    <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end
  assign o_ready    = state_q == IDLE;
  assign o_valid    = state_q == DONE;
  assign o_res      = res_q;
  assign o_hi       = hi_q;
  assign o_zero     = ~|res_q;
  assign o_overflow = ovf_q;
  assign o_divzero  = dz_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vector table plus hand sequences for busy-ignore and mid-op reset.
module tb_alu_muldiv;
  import alu_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, i_valid = 1'b0;
  logic [3:0] i_op = '0;
  logic [31:0] i_A = '0, i_B = '0;
  logic o_ready, o_valid, o_zero, o_overflow, o_divzero;
  logic [31:0] o_res, o_hi;
  int n_tests = 0, n_fail = 0;

  alu_muldiv #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
    .i_A(i_A), .i_B(i_B), .o_valid(o_valid), .o_res(o_res), .o_hi(o_hi), .o_zero(o_zero),
    .o_overflow(o_overflow), .o_divzero(o_divzero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res, hi;
    logic        ovf, dz;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, b, res, hi,
                              input logic ovf, dz, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.hi = hi; v.ovf = ovf; v.dz = dz; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int g = 0;
    @(negedge clk);
    while (!o_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    i_valid = 1'b1; i_op = op; i_A = a; i_B = b;
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!o_valid && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, bad, extra;
    logic [31:0] exp_res, exp_hi;
    int exp_lat;
    vecs.push_back(mk(OP_SUB,  32'd5, 32'd7, 32'hFFFFFFFE, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SUB,  32'd3, 32'd3, 32'h0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_ADD,  32'h7FFFFFFF, 32'd1, 32'h80000000, 0, 1, 0, 1));
    vecs.push_back(mk(OP_SUB,  32'h80000000, 32'd1, 32'h7FFFFFFF, 0, 1, 0, 1));
    vecs.push_back(mk(OP_SRA,  32'd4, 32'h80000010, 32'hF8000001, 0, 0, 0, 1));
    vecs.push_back(mk(OP_ROR,  32'd4, 32'h0000000F, 32'hF0000000, 0, 0, 0, 1));
    vecs.push_back(mk(OP_NOR,  32'd0, 32'd0, 32'hFFFFFFFF, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SLL,  32'd8, 32'h000000FF, 32'h0000FF00, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SRL,  32'd4, 32'h80000000, 32'h08000000, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SLT,  32'hFFFFFFFF, 32'd1, 32'd1, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 1));
    vecs.push_back(mk(OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0, 1));
`ifdef ALU_MULDIV_EN
    vecs.push_back(mk(OP_MULT,  32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF, 0, 0, 34));
    vecs.push_back(mk(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 0, 0, 34));
    vecs.push_back(mk(OP_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 34));
    vecs.push_back(mk(OP_DIVU,  32'd7, 32'd0, 32'hFFFFFFFF, 32'd7, 0, 1, 1));
    vecs.push_back(mk(OP_ADD,   32'd1, 32'd1, 32'd2, 0, 0, 0, 1));
    vecs.push_back(mk(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 0, 34));
    vecs.push_back(mk(OP_DIVU,  32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 34));
    vecs.push_back(mk(OP_DIV,   32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 0, 0, 34));
    vecs.push_back(mk(OP_DIV,   32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 0, 1, 1));
`else
    vecs.push_back(mk(OP_MULT,  32'hFFFFFFFD, 32'd7, 32'h0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_ADD,   32'd1, 32'd1, 32'd2, 0, 0, 0, 1));
    vecs.push_back(mk(OP_DIVU,  32'd7, 32'd0, 32'h0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_DIV,   32'hFFFFFFF9, 32'd2, 32'h0, 0, 0, 0, 1));
`endif
    vecs.push_back(mk(OP_ADD,   32'd10, 32'd20, 32'd30, 0, 0, 0, 1));

    #12;
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_res", o_res, 0);
    chk("rst_hi", o_hi, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_dz", o_divzero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(lat);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_res", i), o_res, vecs[i].res);
      chk($sformatf("v%0d_hi", i), o_hi, vecs[i].hi);
      chk($sformatf("v%0d_zero", i), o_zero, vecs[i].res == 0);
      chk($sformatf("v%0d_ovf", i), o_overflow, vecs[i].ovf);
      chk($sformatf("v%0d_dz", i), o_divzero, vecs[i].dz);
    end

    // Busy engine: a held request must be ignored until the result is delivered.
`ifdef ALU_MULDIV_EN
    exp_res = 32'hFFFFFFEB; exp_hi = 32'hFFFFFFFF; exp_lat = 34;
`else
    exp_res = 32'h0; exp_hi = 32'h0; exp_lat = 1;
`endif
    issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
    i_valid = 1'b1; i_op = OP_ADD; i_A = 32'd1; i_B = 32'd1;
    lat = 1; bad = 0;
    while (!o_valid && lat < 60) begin
      if (o_ready) bad++;
      @(posedge clk);
      #1 lat++;
    end
    i_valid = 1'b0;
    chk("busy_lat", lat, exp_lat);
    chk("busy_ready_low", bad, 0);
    chk("busy_res", o_res, exp_res);
    chk("busy_hi", o_hi, exp_hi);
    extra = 0;
    repeat (4) begin
      @(posedge clk);
      #1 if (o_valid) extra++;
    end
    chk("busy_no_extra_valid", extra, 0);
    chk("busy_res_hold", o_res, exp_res);

    // Asynchronous reset in the middle of a multiply.
    issue(OP_ADD, 32'h7FFFFFFF, 32'd1);
    wait_valid(lat);
    chk("pre_rst_res", o_res, 32'h80000000);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", o_ready, 1);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_res", o_res, 0);
    chk("mid_rst_hi", o_hi, 0);
    chk("mid_rst_ovf", o_overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (o_valid) extra++;
    end
    chk("post_rst_no_valid", extra, 0);
    issue(OP_ADD, 32'd2, 32'd3);
    wait_valid(lat);
    chk("post_rst_lat", lat, 1);
    chk("post_rst_res", o_res, 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised, sequential successor to the combinational datapath ALU.
- Adds valid/ready issue, registered results and an iterative multiply/divide engine with a HI/LO-style dual result.
- Sits in the EX stage; the pipeline stalls on o_ready=0 and captures results on o_valid.

Parameters:
- WIDTH, 32, operand/result width; power of two, ≥8.
- SHW, $clog2(WIDTH), localparam: shift-amount and iteration-counter width.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  operation request
- o_ready  out  1  engine can accept (state IDLE)
- i_op  in  4  opcode (below)
- i_A  in  WIDTH  operand A; i_A[SHW-1:0] is the shift amount for shifts
- i_B  in  WIDTH  operand B; the shifted value for shifts
- o_valid  out  1  one-cycle pulse: results updated
- o_res  out  WIDTH  primary result / product low / quotient
- o_hi  out  WIDTH  product high / remainder; 0 for single-cycle ops
- o_zero  out  1  ~|o_res
- o_overflow  out  1  signed overflow; ADD/SUB only, else 0
- o_divzero  out  1  divisor was 0; DIV/DIVU only

Behaviour:
- Opcodes:
  - 0000 SLL, 0001 SRL, 0010 SRA, 0011 ROR (rotate right)
  - 0100 SLT (signed), 0101 SLTU
  - 0110 ADD, 0111 SUB
  - 1000 AND, 1001 OR, 1010 NOR = ~(A|B), 1011 XOR
  - 1100 MULT, 1101 MULTU, 1110 DIV, 1111 DIVU
- Reset: all outputs 0 except o_ready=1; state IDLE. Reset asserted mid-operation aborts it; no o_valid follows.
- Accept: i_valid & o_ready at edge k. When o_ready=0, i_valid is ignored and not queued. Operands and opcode are latched at accept.
- States:
  - IDLE: o_ready=1.
  - IDLE→DONE for ops 0000–1011 and for DIV/DIVU with B==0. Result is registered at edge k, so latency is 1.
  - IDLE→MUL or IDLE→DIV for the remaining 11xx ops.
  - MUL/DIV: one radix-2 step per cycle for WIDTH cycles (counter counts down from WIDTH-1), then →FIX.
  - FIX: sign correction of magnitudes, result registered, →DONE. Multi-cycle latency is WIDTH+2 (34 at WIDTH=32).
  - DONE: o_valid=1 for exactly one cycle, o_ready=0, →IDLE.
- Issue rate: one op per 2 cycles minimum. Outputs hold their last values between o_valid pulses.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - Overflow: operands same sign and result sign differs (ADD); operands differ in sign and result sign differs from A (SUB).
  - SLT/SLTU return 0 or 1 in bit 0.
- MULT/MULTU: the full 2*WIDTH product goes to {o_hi,o_res}. Signed mode multiplies magnitudes and negates if signs differ.
- DIV/DIVU: restoring division on magnitudes.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - B==0: o_res all ones, o_hi=A, o_divzero=1.
  - Signed MIN/-1: o_res=MIN, o_hi=0, no flag.
- o_overflow and o_divzero are registered with the result and cleared by any later completing op.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: behaviour as above.
- Undefined:
  - MUL/DIV/FIX states, counter and engine are not built.
  - Opcodes 11xx complete in 1 cycle with o_res=0, o_hi=0, o_divzero=0.

Decomposition:
- Package alu_pkg: opcode localparams (OP_SLL..OP_DIVU), state enum (IDLE, MUL, DIV, FIX, DONE), WIDTH default.
- Sub-module muldiv_iter: iterative shift-add / restoring engine with start, signed, op, done, and 2*WIDTH result.
- Top: FSM, combinational ops, output registers.

Test Plan:
- SUB A=5, B=7 → o_res=0xFFFFFFFE, o_overflow=0, o_zero=0, o_valid 1 cycle after accept. SUB 3-3 → o_zero=1.
- ADD A=0x7FFFFFFF, B=1 → o_res=0x80000000, o_overflow=1, o_hi=0.
- SRA A=4, B=0x80000010 → 0xF8000001. ROR A=4, B=0x0000000F → 0xF0000000. NOR A=0, B=0 → 0xFFFFFFFF.
- MULT A=-3, B=7 → o_hi=0xFFFFFFFF, o_res=0xFFFFFFEB, o_valid exactly 34 cycles after accept.
  - o_ready=0 throughout; a second i_valid during this time is ignored.
- DIV A=-7, B=2 → o_res=0xFFFFFFFD, o_hi=0xFFFFFFFF. DIVU A=7, B=0 → o_res=0xFFFFFFFF, o_hi=7, o_divzero=1, latency 1.
- i_rst_n low at cycle 10 of MULTU → outputs 0 and o_ready=1 immediately without a clock edge. No o_valid follows; the next ADD completes normally.
